// File: rtl/rst_seq_gen_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default
// lengths and the length-normalisation helpers.
package rst_seq_gen_pkg;

  // Sequencer state encoding (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_IDLE    = 2'd2;

  // Power-on defaults for the assert length and the release spacing
  localparam int unsigned DEF_ASSERT_CYC = 16;
  localparam int unsigned DEF_GAP_CYC    = 4;

  // A requested length of zero behaves as a length of one
  function automatic logic [31:0] clamp_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

  // Counter preload for a phase of the given length. The counter reaches
  // zero one cycle before the phase ends, so the preload is length-1.
  function automatic logic [31:0] len_to_load(input logic [31:0] len);
    return clamp_len(len) - 32'd1;
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable saturating down-counter used to time both the assert phase and
// the gaps between domain releases.
module rst_seq_cnt
  import rst_seq_gen_pkg::*;
#(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: load has priority, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset to the power-on preload
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_gen.sv
// Reset generator/sequencer: holds every domain in reset for a minimum
// length after power-up or a software request, then releases the domains
// one at a time (bit 0 first) with a fixed spacing between releases.
module rst_seq_gen
  import rst_seq_gen_pkg::*;
#(
  parameter int unsigned NUM_DOM    = 3,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ASSERT_CYC = DEF_ASSERT_CYC,
  parameter int unsigned GAP_CYC    = DEF_GAP_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_req,
  input  logic [CNT_W-1:0]   assert_len,
  input  logic [CNT_W-1:0]   gap_len,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               busy,
  output logic               done
);

  localparam int unsigned IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);
  localparam logic [CNT_W-1:0] DEF_ASSERT_LD = CNT_W'(len_to_load(32'(ASSERT_CYC)));
  localparam logic [CNT_W-1:0] DEF_GAP_LD    = CNT_W'(len_to_load(32'(GAP_CYC)));

  logic [1:0]         state_d,  state_q;
  logic [IDX_W-1:0]   idx_d,    idx_q;
  logic [NUM_DOM-1:0] dom_d,    dom_q;
  logic               busy_d,   busy_q;
  logic               done_d,   done_q;
  logic [CNT_W-1:0]   gap_ld_d, gap_ld_q;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_en;
  logic               cnt_zero;

  rst_seq_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (DEF_ASSERT_LD)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // Sequencer next-state: a request restarts everything; otherwise each
  // counter expiry releases the next domain until the last one is out.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dom_d    = dom_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    gap_ld_d = gap_ld_q;
    cnt_load = 1'b0;
    cnt_val  = gap_ld_q;
    cnt_en   = (state_q != ST_IDLE);

    if (rst_req) begin
      // Request wins over any release due on the same edge, including the
      // final one, so no partial release and no done pulse can escape.
      state_d  = ST_ASSERT;
      idx_d    = '0;
      dom_d    = '0;
      busy_d   = 1'b1;
      gap_ld_d = CNT_W'(len_to_load(32'(gap_len)));
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(len_to_load(32'(assert_len)));
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_zero) begin
            dom_d[0] = 1'b1;
            if (NUM_DOM == 1) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_RELEASE;
              idx_d    = IDX_W'(1);
              cnt_load = 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (cnt_zero) begin
            for (int unsigned i = 0; i < NUM_DOM; i++) begin
              if (idx_q == IDX_W'(i)) begin
                dom_d[i] = 1'b1;
              end
            end
            if (idx_q == LAST_IDX) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d    = idx_q + 1'b1;
              cnt_load = 1'b1;
            end
          end
        end
        ST_IDLE: begin
          cnt_en = 1'b0;
        end
        default: begin
          // Unreachable encoding: recover by rerunning the power-on sequence
          state_d  = ST_ASSERT;
          idx_d    = '0;
          dom_d    = '0;
          busy_d   = 1'b1;
          gap_ld_d = DEF_GAP_LD;
          cnt_load = 1'b1;
          cnt_val  = DEF_ASSERT_LD;
        end
      endcase
    end
  end

  // State, index and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ASSERT;
      idx_q    <= '0;
      dom_q    <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      gap_ld_q <= DEF_GAP_LD;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dom_q    <= dom_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gap_ld_q <= gap_ld_d;
    end
  end

  assign dom_rst_n = dom_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed self-checking bench for rst_seq_gen (NUM_DOM=3, defaults 16/4).
module tb_rst_seq_gen;

  logic       clk;
  logic       rst;
  logic       rst_req;
  logic [7:0] assert_len;
  logic [7:0] gap_len;
  logic [2:0] dom_rst_n;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  rst_seq_gen #(
    .NUM_DOM    (3),
    .CNT_W      (8),
    .ASSERT_CYC (16),
    .GAP_CYC    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rst_req    (rst_req),
    .assert_len (assert_len),
    .gap_len    (gap_len),
    .dom_rst_n  (dom_rst_n),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; afterwards outputs reflect that edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected release pattern k edges after reference edge T
  function automatic logic [2:0] exp_dom(input int l, input int g, input int k);
    int le = (l == 0) ? 1 : l;
    int ge = (g == 0) ? 1 : g;
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (k >= le + i * ge);
    return r;
  endfunction

  function automatic int fin_edge(input int l, input int g);
    int le = (l == 0) ? 1 : l;
    int ge = (g == 0) ? 1 : g;
    return le + 2 * ge;
  endfunction

  task automatic test_reset();
    rst = 1'b1; rst_req = 1'b0; assert_len = 8'd0; gap_len = 8'd0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (dom_rst_n !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_vals cyc%0d: got dom=%b busy=%b done=%b, want 000/1/0", c, dom_rst_n, busy, done);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_power_on();
    for (int k = 1; k <= 28; k++) begin
      tick();
      n_cmp++;
      if (dom_rst_n !== exp_dom(16, 4, k) || busy !== (k < 24) || done !== (k == 24)) begin
        n_bad++;
        $display("FAIL power_on T+%0d: got dom=%b busy=%b done=%b, want %b/%b/%b",
                 k, dom_rst_n, busy, done, exp_dom(16, 4, k), (k < 24), (k == 24));
      end
    end
  endtask

  // Issue a one-cycle request at the next edge and check edge T itself
  task automatic req_pulse(input int l, input int g, input string nm);
    assert_len = 8'(l); gap_len = 8'(g); rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    assert_len = 8'd77; gap_len = 8'd55;  // prove the lengths were latched
    n_cmp++;
    if (dom_rst_n !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s edgeT: got dom=%b busy=%b done=%b, want 000/1/0", nm, dom_rst_n, busy, done);
    end
  endtask

  task automatic test_request_idle();
    int f = fin_edge(3, 2);
    req_pulse(3, 2, "req_idle");
    for (int k = 1; k <= f + 3; k++) begin
      tick();
      n_cmp++;
      if (dom_rst_n !== exp_dom(3, 2, k) || busy !== (k < f) || done !== (k == f)) begin
        n_bad++;
        $display("FAIL req_idle T+%0d: got dom=%b busy=%b done=%b, want %b/%b/%b",
                 k, dom_rst_n, busy, done, exp_dom(3, 2, k), (k < f), (k == f));
      end
    end
  endtask

  task automatic test_zero_len();
    int f = fin_edge(0, 0);
    req_pulse(0, 0, "zero_len");
    for (int k = 1; k <= f + 2; k++) begin
      tick();
      n_cmp++;
      if (dom_rst_n !== exp_dom(0, 0, k) || busy !== (k < f) || done !== (k == f)) begin
        n_bad++;
        $display("FAIL zero_len T+%0d: got dom=%b busy=%b done=%b, want %b/%b/%b",
                 k, dom_rst_n, busy, done, exp_dom(0, 0, k), (k < f), (k == f));
      end
    end
  endtask

  task automatic test_req_mid_power_on();
    int f = fin_edge(5, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 1; k <= 17; k++) tick();
    n_cmp++;
    if (dom_rst_n !== 3'b001) begin
      n_bad++;
      $display("FAIL mid_pre T+17: got dom=%b, want 001", dom_rst_n);
    end
    req_pulse(5, 3, "req_mid");
    for (int k = 1; k <= f + 3; k++) begin
      tick();
      n_cmp++;
      if (dom_rst_n !== exp_dom(5, 3, k) || busy !== (k < f) || done !== (k == f)) begin
        n_bad++;
        $display("FAIL req_mid T+%0d: got dom=%b busy=%b done=%b, want %b/%b/%b",
                 k, dom_rst_n, busy, done, exp_dom(5, 3, k), (k < f), (k == f));
      end
    end
  endtask

  task automatic test_req_held();
    int f = fin_edge(2, 1);
    assert_len = 8'd2; gap_len = 8'd1; rst_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (dom_rst_n !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL req_held cyc%0d: got dom=%b busy=%b done=%b, want 000/1/0", c, dom_rst_n, busy, done);
      end
    end
    rst_req = 1'b0;
    for (int k = 1; k <= f + 2; k++) begin
      tick();
      n_cmp++;
      if (dom_rst_n !== exp_dom(2, 1, k) || busy !== (k < f) || done !== (k == f)) begin
        n_bad++;
        $display("FAIL req_held T+%0d: got dom=%b busy=%b done=%b, want %b/%b/%b",
                 k, dom_rst_n, busy, done, exp_dom(2, 1, k), (k < f), (k == f));
      end
    end
  endtask

  task automatic test_req_on_final();
    int f = fin_edge(3, 2);
    req_pulse(3, 2, "final_a");
    for (int k = 1; k < f; k++) tick();
    req_pulse(4, 1, "final_b");  // lands on the edge of the last release
    for (int k = 1; k <= fin_edge(4, 1) + 1; k++) begin
      tick();
      n_cmp++;
      if (dom_rst_n !== exp_dom(4, 1, k) || done !== (k == fin_edge(4, 1))) begin
        n_bad++;
        $display("FAIL req_final T+%0d: got dom=%b done=%b, want %b/%b",
                 k, dom_rst_n, done, exp_dom(4, 1, k), (k == fin_edge(4, 1)));
      end
    end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 1; k <= 21; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (dom_rst_n !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid edge: got dom=%b busy=%b done=%b, want 000/1/0", dom_rst_n, busy, done);
    end
    for (int k = 1; k <= 27; k++) begin
      tick();
      n_cmp++;
      if (dom_rst_n !== exp_dom(16, 4, k) || busy !== (k < 24) || done !== (k == 24)) begin
        n_bad++;
        $display("FAIL rst_mid T+%0d: got dom=%b busy=%b done=%b, want %b/%b/%b",
                 k, dom_rst_n, busy, done, exp_dom(16, 4, k), (k < 24), (k == 24));
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_request_idle();
    test_zero_len();
    test_req_mid_power_on();
    test_req_held();
    test_req_on_final();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Reset generator and sequencer that produces the domain resets consumed by the per-domain reset synchronizers.
- On power-up or a software reset request, it asserts every domain reset at once for a minimum length.
- It then releases the domains one at a time, in a fixed order, with a configurable spacing between releases.
- It sits in the always-on reference clock domain, next to the system controller.

Parameters:
- NUM_DOM, 3, number of reset domains sequenced (>=1).
- CNT_W, 8, width of the length counters and of the length config inputs.
- ASSERT_CYC, 16, default assert length used for the power-on sequence (1..2^CNT_W-1).
- GAP_CYC, 4, default release spacing used for the power-on sequence (1..2^CNT_W-1).

Ports:
- clk, in, 1, reference clock.
- rst, in, 1, synchronous, active-high reset.
- rst_req, in, 1, software reset request; sampled each cycle, level or pulse.
- assert_len, in, CNT_W, assert length in cycles; latched when rst_req is accepted.
- gap_len, in, CNT_W, release spacing in cycles; latched when rst_req is accepted.
- dom_rst_n, out, NUM_DOM, active-low domain resets; bit 0 is released first.
- busy, out, 1, high while any domain is still held in reset.
- done, out, 1, one-cycle pulse when the last domain is released.

Behaviour:
- Reset is synchronous and active-high. While rst=1:
  - dom_rst_n = all 0, busy = 1, done = 0.
  - State = ASSERT; the latched lengths are loaded with ASSERT_CYC and GAP_CYC.
- After rst falls, the power-on sequence runs automatically. Its reference edge T is the last edge at which rst=1.
- States:
  - ASSERT: all domains held; counts L cycles.
  - RELEASE: releases domain idx, waits G cycles, then advances idx.
  - IDLE: all domains released.
- Request acceptance: rst_req=1 is accepted at edge T in any state.
  - All dom_rst_n bits are 0 from that edge onward.
  - busy = 1.
  - assert_len and gap_len are latched as L and G.
  - State = ASSERT, counter cleared, idx = 0.
- Length rules: a value of 0 is treated as 1 for both L and G. No other clamping; the counter is CNT_W bits wide and does not wrap within a phase.
- Release timing:
  - dom_rst_n[0] rises at edge T+L.
  - dom_rst_n[i] rises at edge T+L+i*G.
  - Once a bit is released it stays 1 until the next accepted request or rst.
- done: goes to 1 at the same edge as the last release (T+L+(NUM_DOM-1)*G) and returns to 0 on the following edge.
- busy: falls at that same edge; state becomes IDLE.
- NUM_DOM=1: the sequence is ASSERT then IDLE directly; G is unused.
- rst_req held high keeps restarting the sequence. Every domain stays in reset, busy stays 1, and done never pulses. The sequence starts on the first low cycle, timed from the last high edge.
- Request during ASSERT: restarts the count and re-latches the lengths; no glitch on dom_rst_n.
- Request during RELEASE or IDLE: every released domain is re-asserted at edge T. There is no partial release.
- Request coinciding with the final release edge: the request wins. dom_rst_n stays all 0 and done does not pulse.
- rst mid-sequence: immediate synchronous return to the reset values, then the power-on sequence with default lengths.
- All outputs are registered directly, with no combinational path from inputs to outputs.
- dom_rst_n feeds the domain reset synchronizers, which may sit in other clocks; that crossing is their concern.

Decomposition:
- Shared package holds:
  - State encoding: ASSERT, RELEASE, IDLE (2-bit).
  - Default-length constants.
  - Helper function: zero-length to 1.
- Sub-module rst_seq_cnt: a loadable down-counter (CNT_W bits, load, en, zero flag), used for both the assert phase and the gap phase.
- FSM, idx register and output registers live in the top level.

Test Plan:
- Power-on, defaults 16/4, NUM_DOM=3, rst high for 5 cycles then low; T = last rst-high edge → dom_rst_n=000 until T+16; bit0 at T+16, bit1 at T+20, bit2 at T+24; done pulses for one cycle at T+24; busy low from T+24.
- In IDLE, rst_req one-cycle pulse at edge T with assert_len=3, gap_len=2 → dom_rst_n=000 at T; 001 at T+3, 011 at T+5, 111 at T+7; one done pulse.
- assert_len=0, gap_len=0, request → L=G=1: releases at T+1, T+2, T+3.
- Request at T+18 during the default power-on sequence (dom_rst_n=001) → dom_rst_n=000 at T+18; new sequence timed from T+18 with the latched lengths; no done pulse from the aborted sequence.
- rst_req held high for 10 cycles → dom_rst_n=000 and busy=1 throughout; release timed from the last high edge.
- rst asserted at T+22 (mid-release) → next edge: dom_rst_n=000, busy=1, done=0; after rst falls, default 16/4 timing is repeated exactly.
